mult_div_unit: RTL and testbench
================================

# mult_div_unit

Multi-cycle multiply/divide unit with its own sequencer, owning the HI/LO register pair. It sits in the execute stage beside the ALU and accepts one MIPS multiply/divide/move-to instruction at a time. It holds `busy` for the operation's fixed latency so the hazard unit can stall following HI/LO users.

## Interface
Parameters:
- `MULT_CYCLES`, default 5: busy cycles for `mult`/`multu`; legal range 1–15.
- `DIV_CYCLES`, default 10: busy cycles for `div`/`divu`; legal range 1–15.

Ports:
- `clk`  in  1  sole clock; all state changes on the rising edge.
- `reset`  in  1  asynchronous, active-low; clears all state immediately.
- `start`  in  1  accept request; sampled on the rising edge.
- `cancel`  in  1  kill this cycle's request (exception/interrupt in a later stage); overrides `start`.
- `md_op`  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo, 7 reserved (treated as none).
- `in1`  in  32  rs operand (dividend; mthi/mtlo source).
- `in2`  in  32  rt operand (divisor).
- `busy`  out  1  registered; high while a mult/div is in flight.
- `hi`  out  32  HI register.
- `lo`  out  32  LO register.

## Operation
- States: IDLE, RUN. A 4-bit down-counter `cnt` and latched operation/operands are kept.
- Accept condition, checked at each edge: `start & ~cancel & ~busy & md_op != 0`.
- The unit ignores `start` while `busy`. There is no queue; the pipeline must stall instead.
- mult/multu/div/divu in IDLE:
  - Latch `md_op`, `in1`, `in2`.
  - Load `cnt` with the op's cycle count minus 1.
  - Go to RUN and set `busy` = 1.
- mthi/mtlo in IDLE:
  - Write `in1` to HI or LO on that edge.
  - State stays IDLE and `busy` stays 0.
- RUN:
  - When `cnt` ≠ 0, decrement it.
  - When `cnt` = 0: write the result to HI/LO, clear `busy`, and return to IDLE.
- Result is computed from the latched operands, never from the live inputs.
- Arithmetic:
  - mult: signed 32×32 → 64; HI = bits [63:32], LO = bits [31:0].
  - multu: same, unsigned.
  - div: LO = signed quotient truncated toward zero; HI = remainder with the sign of the dividend.
  - divu: unsigned quotient in LO, remainder in HI.
  - Signed overflow 0x8000_0000 / 0xFFFF_FFFF: LO = 0x8000_0000, HI = 0.
  - Divisor zero (div or divu): still busy for `DIV_CYCLES`; HI and LO left unchanged at completion.
- `cancel` only blocks acceptance in its own cycle. An operation already in RUN always completes.
- Reserved or zero `md_op` with `start`: no effect.

## Timing
- Reset values: `busy` = 0, `hi` = 0, `lo` = 0, state IDLE, `cnt` = 0. Values apply asynchronously on `reset` low and hold until the first edge after release.
- mult/div accepted at edge E0:
  - `busy` is high from E0 to edge E0+N, for exactly N cycles (N = `MULT_CYCLES` or `DIV_CYCLES`).
  - HI/LO take the new values at edge E0+N, the same edge where `busy` falls.
- A new request may be accepted at edge E0+N+1. Back-to-back requests have one idle cycle minimum.
- mthi/mtlo accepted at E0: `hi`/`lo` are visible after E0. Zero stall.
- `busy` is a registered output. The hazard unit stalls on `busy | (start & md_op in 1..4)`.
- Reset asserted mid-RUN aborts the operation: HI/LO = 0 and `busy` = 0 immediately. The partial result is discarded.

## Configuration
- `MDU_DIV_EN`:
  - Defined: div/divu are implemented as specified.
  - Undefined: no divider logic is synthesized; `md_op` 3/4 are treated as none. No busy, HI/LO unchanged.
- mult/multu/mthi/mtlo are unaffected in both cases.

## Test plan
- mult −3 × 5 at E0 → `busy` high 5 cycles; at E0+5, HI = 0xFFFF_FFFF and LO = 0xFFFF_FFF1.
- multu 0xFFFF_FFFF × 2 → HI = 0x0000_0001, LO = 0xFFFF_FFFE.
- div −7 / 2 → `busy` high 10 cycles, then LO = 0xFFFF_FFFD and HI = 0xFFFF_FFFF. divu 7 / 0 with prior HI = 0x11, LO = 0x22 → after 10 cycles HI/LO unchanged.
- mthi 0xDEAD_BEEF, then mult 2 × 3 issued, then mtlo 0x55 presented with `start` during busy:
  - mtlo is ignored.
  - Final HI = 0, LO = 6.
  - Changing `in1`/`in2` mid-RUN does not alter the result.
- mult with `start` = 1 and `cancel` = 1 → `busy` stays 0 and HI/LO unchanged.
- Reset pulsed during div cycle 4 → `busy`, HI, LO = 0 immediately; the next div after release completes normally.
- Without `MDU_DIV_EN`, div 8 / 2 → `busy` stays 0 and HI/LO unchanged.

Source files
------------

// File: rtl/mult_div_unit.sv
// -----------------------------------------------------------------------------
// mult_div_unit
//
// Multi-cycle multiply/divide unit for the execute stage. It owns the HI/LO
// register pair and runs one MIPS mult/multu/div/divu at a time with a fixed
// latency. mthi/mtlo write HI/LO directly with zero stall.
//
// Optional feature macro: MDU_DIV_EN
//   defined   : div/divu implemented.
//   undefined : no divider hardware; md_op 3/4 behave like "none".
//
// Parameters
//   MULT_CYCLES : busy cycles for mult/multu (1..15)
//   DIV_CYCLES  : busy cycles for div/divu   (1..15)
//
// Ports
//   clk        in   1   sole clock, rising edge
//   reset      in   1   asynchronous, active-low; clears all state
//   start      in   1   request this cycle
//   cancel     in   1   kill this cycle's request (overrides start)
//   md_op      in   3   0 none, 1 mult, 2 multu, 3 div, 4 divu,
//                       5 mthi, 6 mtlo, 7 reserved (none)
//   in1        in   32  rs operand (dividend, mthi/mtlo source)
//   in2        in   32  rt operand (divisor)
//   busy       out  1   registered; high while a mult/div is in flight
//   hi         out  32  HI register
//   lo         out  32  LO register
//   dbg_state  out  1   sequencer state (0 IDLE, 1 RUN) for observation
//
// Handshake: a request is accepted on a rising edge when
//   start & ~cancel & ~busy & (md_op is a supported operation).
// There is no queue; while busy is high start is ignored and the pipeline
// must stall. An accepted mult/div with latency N keeps busy high for exactly
// N cycles; HI/LO update on the same edge that busy falls, so the earliest
// following acceptance is one edge later.
// -----------------------------------------------------------------------------
module mult_div_unit #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic        cancel,
    input  logic [2:0]  md_op,
    input  logic [31:0] in1,
    input  logic [31:0] in2,
    output logic        busy,
    output logic [31:0] hi,
    output logic [31:0] lo,
    output logic        dbg_state
);

    localparam logic [2:0] OP_MULT  = 3'd1;
    localparam logic [2:0] OP_MULTU = 3'd2;
    localparam logic [2:0] OP_MTHI  = 3'd5;
    localparam logic [2:0] OP_MTLO  = 3'd6;

    // Counter is loaded with latency-1; the completion edge is the one that
    // sees cnt == 0 while in RUN.
    localparam logic [3:0] MULT_LOAD = 4'(MULT_CYCLES - 1);

`ifdef MDU_DIV_EN
    localparam logic [2:0] OP_DIV   = 3'd3;
    localparam logic [2:0] OP_DIVU  = 3'd4;
    localparam logic [3:0] DIV_LOAD = 4'(DIV_CYCLES - 1);
`endif

    typedef enum logic {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q,   cnt_d;
    logic [2:0]  op_q,    op_d;
    logic [31:0] a_q,     a_d;
    logic [31:0] b_q,     b_d;
    logic [31:0] hi_q,    hi_d;
    logic [31:0] lo_q,    lo_d;

    // -------------------------------------------------------------------------
    // Request decode
    // -------------------------------------------------------------------------
    logic req_ok;
    logic op_is_mul;
    logic op_is_div;
    logic op_is_mthi;
    logic op_is_mtlo;
    logic long_accept;
    logic [3:0] load_val;

    always_comb begin
        // busy is exactly "state is RUN", so IDLE doubles as ~busy here.
        req_ok     = start & ~cancel & (state_q == S_IDLE);
        op_is_mul  = (md_op == OP_MULT) | (md_op == OP_MULTU);
`ifdef MDU_DIV_EN
        op_is_div  = (md_op == OP_DIV) | (md_op == OP_DIVU);
        load_val   = op_is_div ? DIV_LOAD : MULT_LOAD;
`else
        op_is_div  = 1'b0;
        load_val   = MULT_LOAD;
`endif
        op_is_mthi = (md_op == OP_MTHI);
        op_is_mtlo = (md_op == OP_MTLO);
        long_accept = req_ok & (op_is_mul | op_is_div);
    end

    // -------------------------------------------------------------------------
    // Multiplier: operands are sign- or zero-extended to 64 bits; the low 64
    // bits of a 64x64 product are then correct for both signednesses.
    // -------------------------------------------------------------------------
    logic        mul_signed;
    logic [63:0] mul_a;
    logic [63:0] mul_b;
    logic [63:0] mul_p;

    always_comb begin
        mul_signed = (op_q == OP_MULT);
        mul_a      = {{32{mul_signed & a_q[31]}}, a_q};
        mul_b      = {{32{mul_signed & b_q[31]}}, b_q};
        mul_p      = mul_a * mul_b;
    end

`ifdef MDU_DIV_EN
    // -------------------------------------------------------------------------
    // Divider: unsigned divide of magnitudes, then sign fix-up. Quotient is
    // negated when operand signs differ (truncation toward zero); remainder
    // takes the dividend's sign. 0x8000_0000 / -1 falls out naturally:
    // |a| = 0x8000_0000, q = 0x8000_0000, negation wraps back to itself, r = 0.
    // -------------------------------------------------------------------------
    logic        div_signed;
    logic        a_neg;
    logic        b_neg;
    logic        div_by_zero;
    logic [31:0] a_mag;
    logic [31:0] b_mag;
    logic [31:0] b_safe;
    logic [31:0] q_mag;
    logic [31:0] r_mag;
    logic [31:0] quot;
    logic [31:0] rem;

    always_comb begin
        div_signed  = (op_q == OP_DIV);
        a_neg       = div_signed & a_q[31];
        b_neg       = div_signed & b_q[31];
        a_mag       = a_neg ? (32'd0 - a_q) : a_q;
        b_mag       = b_neg ? (32'd0 - b_q) : b_q;
        div_by_zero = (b_q == 32'd0);
        // Keep the divider free of a zero divisor; the result is discarded
        // in that case anyway.
        b_safe      = div_by_zero ? 32'd1 : b_mag;
        q_mag       = a_mag / b_safe;
        r_mag       = a_mag % b_safe;
        quot        = (a_neg ^ b_neg) ? (32'd0 - q_mag) : q_mag;
        rem         = a_neg ? (32'd0 - r_mag) : r_mag;
    end
`endif

    // -------------------------------------------------------------------------
    // State register
    // -------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
            cnt_q   <= 4'd0;
            op_q    <= 3'd0;
            a_q     <= 32'd0;
            b_q     <= 32'd0;
            hi_q    <= 32'd0;
            lo_q    <= 32'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state logic: sequencing, counter and operand latch
    // -------------------------------------------------------------------------
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        case (state_q)
            S_IDLE: begin
                if (long_accept) begin
                    state_d = S_RUN;
                    cnt_d   = load_val;
                    op_d    = md_op;
                    a_d     = in1;
                    b_d     = in2;
                end
            end
            S_RUN: begin
                if (cnt_q != 4'd0) begin
                    cnt_d = cnt_q - 4'd1;
                end else begin
                    state_d = S_IDLE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // -------------------------------------------------------------------------
    // Output logic: HI/LO writes and status
    // -------------------------------------------------------------------------
    always_comb begin
        hi_d = hi_q;
        lo_d = lo_q;
        if (state_q == S_IDLE) begin
            if (req_ok & op_is_mthi) hi_d = in1;
            if (req_ok & op_is_mtlo) lo_d = in1;
        end else if (cnt_q == 4'd0) begin
            // Completion edge: result comes only from the latched operands.
            case (op_q)
                OP_MULT, OP_MULTU: begin
                    hi_d = mul_p[63:32];
                    lo_d = mul_p[31:0];
                end
`ifdef MDU_DIV_EN
                OP_DIV, OP_DIVU: begin
                    // Divide by zero still costs the full latency but leaves
                    // HI/LO untouched.
                    if (!div_by_zero) begin
                        hi_d = rem;
                        lo_d = quot;
                    end
                end
`endif
                default: begin
                end
            endcase
        end
    end

    assign busy      = (state_q == S_RUN);
    assign dbg_state = state_q;
    assign hi        = hi_q;
    assign lo        = lo_q;

endmodule

// File: tb/tb_mult_div_unit.sv
// Self-checking bench for mult_div_unit. Expected HI/LO pairs are produced
// by a behavioural model when stimulus is driven, queued, and popped when the
// unit reports completion (busy low).
module tb_mult_div_unit;

  localparam int MC = 5;
  localparam int DC = 10;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic        cancel;
  logic [2:0]  md_op;
  logic [31:0] in1;
  logic [31:0] in2;
  logic        busy;
  logic [31:0] hi;
  logic [31:0] lo;
  logic        dbg_state;

  int n_cmp = 0;
  int n_err = 0;

  logic [63:0] exp_q[$];
  logic [63:0] m_hilo;   // model view of {HI, LO}

  mult_div_unit #(.MULT_CYCLES(MC), .DIV_CYCLES(DC)) dut (
    .clk       (clk),
    .reset     (reset),
    .start     (start),
    .cancel    (cancel),
    .md_op     (md_op),
    .in1       (in1),
    .in2       (in2),
    .busy      (busy),
    .hi        (hi),
    .lo        (lo),
    .dbg_state (dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- model ----------------
  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a,
                                        input logic [31:0] b, input logic [63:0] cur);
    longint          sa, sb;
    longint unsigned ua, ub;
    int              da, db, q, r;
    case (op)
      3'd1: begin sa = $signed(a); sb = $signed(b); return 64'(sa * sb); end
      3'd2: begin ua = a; ub = b; return 64'(ua * ub); end
`ifdef MDU_DIV_EN
      3'd3: begin
        if (b == 32'd0) return cur;
        if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return {32'h0, 32'h8000_0000};
        da = a; db = b; q = da / db; r = da % db;
        return {32'(r), 32'(q)};
      end
      3'd4: begin
        if (b == 32'd0) return cur;
        return {a % b, a / b};
      end
`endif
      3'd5: return {a, cur[31:0]};
      3'd6: return {cur[63:32], a};
      default: return cur;
    endcase
  endfunction

  // ---------------- driver ----------------
  // Presents one request for one edge, then scrambles the live operands and
  // counts busy cycles (bounded).
  task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                        input logic c, output int cycles);
    @(negedge clk);
    md_op = op; in1 = a; in2 = b; cancel = c; start = 1'b1;
    @(negedge clk);
    start = 1'b0; cancel = 1'b0; md_op = 3'd0;
    in1 = $urandom; in2 = $urandom;
    cycles = 0;
    while (busy === 1'b1 && cycles < 64) begin
      cycles++;
      @(negedge clk);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset;
    reset = 1'b0; start = 1'b0; cancel = 1'b0; md_op = 3'd0; in1 = '0; in2 = '0;
    #3;
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
    n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL reset_hilo got=%h exp=0", {hi, lo}); end
    n_cmp++; if (dbg_state !== 1'b0) begin n_err++; $display("FAIL reset_state got=%b exp=0", dbg_state); end
    @(negedge clk); reset = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0 || {hi, lo} !== 64'd0) begin
      n_err++; $display("FAIL post_reset got busy=%b hilo=%h exp busy=0 hilo=0", busy, {hi, lo});
    end
    m_hilo = 64'd0;
  endtask

  task automatic test_mult;
    logic [2:0]  ops [8] = '{3'd1, 3'd2, 3'd1, 3'd2, 3'd1, 3'd1, 3'd2, 3'd1};
    logic [31:0] as  [8] = '{32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'h7FFF_FFFF, 32'h0, 32'h1234_5678, 32'hFFFF_FFFF};
    logic [31:0] bs  [8] = '{32'd5, 32'd2, 32'h8000_0000, 32'hFFFF_FFFF,
                             32'hFFFF_FFFF, 32'hDEAD_BEEF, 32'h9ABC_DEF0, 32'hFFFF_FFFF};
    logic [63:0] e;
    int cyc;
    for (int i = 0; i < 14; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      if (i < 8) begin op = ops[i]; a = as[i]; b = bs[i]; end
      else begin op = 3'($urandom_range(1, 2)); a = $urandom; b = $urandom; end
      m_hilo = model(op, a, b, m_hilo);
      exp_q.push_back(m_hilo);
      run_op(op, a, b, 1'b0, cyc);
      n_cmp++; if (cyc != MC) begin n_err++; $display("FAIL mult_latency[%0d] got=%0d exp=%0d", i, cyc, MC); end
      e = exp_q.pop_front();
      n_cmp++; if ({hi, lo} !== e) begin n_err++; $display("FAIL mult_result[%0d] got=%h exp=%h", i, {hi, lo}, e); end
    end
  endtask

  task automatic test_div;
    int cyc;
    logic [63:0] e;
`ifdef MDU_DIV_EN
    logic [2:0]  ops [6] = '{3'd3, 3'd4, 3'd3, 3'd3, 3'd4, 3'd3};
    logic [31:0] as  [6] = '{32'hFFFF_FFF9, 32'd7, 32'h8000_0000, 32'd7, 32'hFFFF_FFFF, 32'd100};
    logic [31:0] bs  [6] = '{32'd2, 32'd0, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'd16, 32'd0};
    // Seed HI/LO so the divide-by-zero cases have something to preserve.
    m_hilo = {32'h11, 32'h22};
    run_op(3'd5, 32'h11, 32'h0, 1'b0, cyc);
    run_op(3'd6, 32'h22, 32'h0, 1'b0, cyc);
    n_cmp++; if ({hi, lo} !== m_hilo) begin n_err++; $display("FAIL div_seed got=%h exp=%h", {hi, lo}, m_hilo); end
    for (int i = 0; i < 10; i++) begin
      logic [2:0]  op;
      logic [31:0] a, b;
      if (i < 6) begin op = ops[i]; a = as[i]; b = bs[i]; end
      else begin op = 3'($urandom_range(3, 4)); a = $urandom; b = $urandom_range(0, 3) == 0 ? 32'd0 : $urandom; end
      if (i == 1) begin
        // divu 7/0 with HI=0x11, LO=0x22 beforehand
        m_hilo = {32'h11, 32'h22};
        run_op(3'd5, 32'h11, 32'h0, 1'b0, cyc);
        run_op(3'd6, 32'h22, 32'h0, 1'b0, cyc);
      end
      m_hilo = model(op, a, b, m_hilo);
      exp_q.push_back(m_hilo);
      run_op(op, a, b, 1'b0, cyc);
      n_cmp++; if (cyc != DC) begin n_err++; $display("FAIL div_latency[%0d] got=%0d exp=%0d", i, cyc, DC); end
      e = exp_q.pop_front();
      n_cmp++; if ({hi, lo} !== e) begin n_err++; $display("FAIL div_result[%0d] got=%h exp=%h", i, {hi, lo}, e); end
    end
`else
    // Divider absent: div/divu must act as "none".
    m_hilo = {32'hAAAA_0001, 32'h5555_0002};
    run_op(3'd5, 32'hAAAA_0001, 32'h0, 1'b0, cyc);
    run_op(3'd6, 32'h5555_0002, 32'h0, 1'b0, cyc);
    for (int i = 0; i < 2; i++) begin
      exp_q.push_back(m_hilo);
      run_op(3'(3 + i), 32'd8, 32'd2, 1'b0, cyc);
      n_cmp++; if (cyc != 0) begin n_err++; $display("FAIL nodiv_busy[%0d] got=%0d exp=0", i, cyc); end
      e = exp_q.pop_front();
      n_cmp++; if ({hi, lo} !== e) begin n_err++; $display("FAIL nodiv_hilo[%0d] got=%h exp=%h", i, {hi, lo}, e); end
    end
`endif
  endtask

  task automatic test_mthi_mtlo_ignore;
    int cyc;
    logic [63:0] e;
    m_hilo = model(3'd5, 32'hDEAD_BEEF, 32'h0, m_hilo);
    run_op(3'd5, 32'hDEAD_BEEF, 32'h0, 1'b0, cyc);
    n_cmp++; if (cyc != 0 || hi !== 32'hDEAD_BEEF) begin
      n_err++; $display("FAIL mthi got busy_cyc=%0d hi=%h exp 0 / deadbeef", cyc, hi);
    end
    // mult 2*3, then hold mtlo 0x55 with start high during busy.
    m_hilo = model(3'd1, 32'd2, 32'd3, m_hilo);
    exp_q.push_back(m_hilo);
    @(negedge clk);
    md_op = 3'd1; in1 = 32'd2; in2 = 32'd3; start = 1'b1;
    @(negedge clk);
    md_op = 3'd6; in1 = 32'h55; in2 = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 64) begin
      cyc++;
      n_cmp++; if (lo === 32'h55) begin n_err++; $display("FAIL mtlo_during_busy got lo=%h exp not 55", lo); end
      @(negedge clk);
    end
    start = 1'b0; md_op = 3'd0;
    n_cmp++; if (cyc != MC) begin n_err++; $display("FAIL ignore_latency got=%0d exp=%0d", cyc, MC); end
    e = exp_q.pop_front();
    n_cmp++; if ({hi, lo} !== e || e !== {32'h0, 32'h6}) begin
      n_err++; $display("FAIL ignore_result got=%h exp=%h", {hi, lo}, e);
    end
    // mtlo after busy returns to normal takes effect with no stall.
    m_hilo = model(3'd6, 32'h55, 32'h0, m_hilo);
    run_op(3'd6, 32'h55, 32'h0, 1'b0, cyc);
    n_cmp++; if ({hi, lo} !== m_hilo || cyc != 0) begin
      n_err++; $display("FAIL mtlo got=%h cyc=%0d exp=%h cyc=0", {hi, lo}, cyc, m_hilo);
    end
  endtask

  task automatic test_cancel_and_none;
    int cyc;
    logic [2:0] ops [5] = '{3'd1, 3'd2, 3'd5, 3'd0, 3'd7};
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(m_hilo);
      // cancel on the real ops; plain start on none/reserved
      run_op(ops[i], $urandom, $urandom, (i < 3), cyc);
      n_cmp++; if (cyc != 0) begin n_err++; $display("FAIL cancel_busy[%0d] got=%0d exp=0", i, cyc); end
      n_cmp++; if ({hi, lo} !== exp_q.pop_front()) begin
        n_err++; $display("FAIL cancel_hilo[%0d] got=%h exp=%h", i, {hi, lo}, m_hilo);
      end
    end
  endtask

  task automatic test_back_to_back;
    logic [63:0] e;
    int cyc;
    logic [31:0] a2, b2;
    a2 = $urandom; b2 = $urandom;
    m_hilo = model(3'd2, 32'd1000, 32'd3000, m_hilo);
    exp_q.push_back(m_hilo);
    m_hilo = model(3'd1, a2, b2, m_hilo);
    exp_q.push_back(m_hilo);
    @(negedge clk);
    md_op = 3'd2; in1 = 32'd1000; in2 = 32'd3000; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (MC - 1) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL b2b_last_busy got=%b exp=1", busy); end
    // Second request held across the completion edge (ignored) and the next.
    md_op = 3'd1; in1 = a2; in2 = b2; start = 1'b1;
    @(negedge clk);
    n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL b2b_gap got=%b exp=0", busy); end
    e = exp_q.pop_front();
    n_cmp++; if ({hi, lo} !== e) begin n_err++; $display("FAIL b2b_first got=%h exp=%h", {hi, lo}, e); end
    @(negedge clk);
    start = 1'b0; md_op = 3'd0; in1 = $urandom; in2 = $urandom;
    cyc = 0;
    while (busy === 1'b1 && cyc < 64) begin cyc++; @(negedge clk); end
    n_cmp++; if (cyc != MC) begin n_err++; $display("FAIL b2b_second_latency got=%0d exp=%0d", cyc, MC); end
    e = exp_q.pop_front();
    n_cmp++; if ({hi, lo} !== e) begin n_err++; $display("FAIL b2b_second got=%h exp=%h", {hi, lo}, e); end
  endtask

  task automatic test_reset_mid_run;
    int cyc;
    int lat;
    logic [2:0] op;
    logic [63:0] e;
`ifdef MDU_DIV_EN
    op = 3'd3; lat = DC;
`else
    op = 3'd1; lat = MC;
`endif
    m_hilo = model(3'd5, 32'hCAFE_F00D, 32'h0, m_hilo);
    run_op(3'd5, 32'hCAFE_F00D, 32'h0, 1'b0, cyc);
    @(negedge clk);
    md_op = op; in1 = 32'd40; in2 = 32'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0; md_op = 3'd0;
    repeat (3) @(negedge clk);
    n_cmp++; if (busy !== 1'b1) begin n_err++; $display("FAIL rst_pre_busy got=%b exp=1", busy); end
    #2 reset = 1'b0;
    #1;
    n_cmp++; if (busy !== 1'b0 || dbg_state !== 1'b0) begin
      n_err++; $display("FAIL rst_async_busy got=%b state=%b exp 0/0", busy, dbg_state);
    end
    n_cmp++; if ({hi, lo} !== 64'd0) begin n_err++; $display("FAIL rst_async_hilo got=%h exp=0", {hi, lo}); end
    @(negedge clk);
    reset = 1'b1;
    m_hilo = 64'd0;
    exp_q.delete();
    m_hilo = model(op, 32'hFFFF_FF00, 32'd9, m_hilo);
    exp_q.push_back(m_hilo);
    run_op(op, 32'hFFFF_FF00, 32'd9, 1'b0, cyc);
    n_cmp++; if (cyc != lat) begin n_err++; $display("FAIL rst_after_latency got=%0d exp=%0d", cyc, lat); end
    e = exp_q.pop_front();
    n_cmp++; if ({hi, lo} !== e) begin n_err++; $display("FAIL rst_after_result got=%h exp=%h", {hi, lo}, e); end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    test_reset();
    test_mult();
    test_div();
    test_mthi_mtlo_ignore();
    test_cancel_and_none();
    test_back_to_back();
    test_reset_mid_run();
    n_cmp++; if (exp_q.size() != 0) begin n_err++; $display("FAIL scoreboard_leftover got=%0d exp=0", exp_q.size()); end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
